// File: rtl/seq_det_param_if.sv
// Bundle of serial input, runtime configuration and match outputs for seq_det_param.
// The master side drives the bit stream and configuration. The slave side is the detector.
interface seq_det_param_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    logic               in_valid;
    logic               in_bit;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [4:0]         cfg_len;
    logic               cfg_overlap;
    logic               cfg_moore;
    logic               out_match;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore,
        input  out_match, match_cnt
    );

    modport slave (
        input  in_valid, in_bit, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_moore,
        output out_match, match_cnt
    );
endinterface

// File: rtl/seq_det_param.sv
// Runtime-configurable serial pattern detector with overlap/non-overlap matching,
// Mealy/Moore output timing and a saturating match counter.
module seq_det_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    seq_det_param_if.slave    bus
);
    localparam logic [4:0]         LEN_MAX  = 5'(MAX_LEN);
    localparam logic [4:0]         FILL_MAX = 5'(MAX_LEN - 1);
    localparam logic [MAX_LEN-1:0] PAT_RST  = MAX_LEN'(3'b101);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    logic [MAX_LEN-1:0] r_pat;
    logic [4:0]         r_len;
    logic               r_ovl;
    logic               r_moore;
    // Only the newest MAX_LEN-1 bits can take part in a compare, so no more are kept.
    logic [MAX_LEN-2:0] r_hist;
    logic [4:0]         r_fill;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_moore;

    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_window;
    logic [4:0]         w_len_clamped;
    logic               w_match;
    logic               w_enough;
    logic               w_hit;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign w_mask[gi] = (5'(gi) < r_len);
        end
    endgenerate

    assign w_window = {r_hist, bus.in_bit};
    assign w_match  = ((w_window ^ r_pat) & w_mask) == '0;
    assign w_enough = r_fill >= (r_len - 5'd1);
    // A bit arriving alongside reset or cfg_load is discarded, so it can never hit.
    assign w_hit    = rstn & bus.in_valid & ~bus.cfg_load & w_enough & w_match;

    always_comb begin
        w_len_clamped = bus.cfg_len;
        if (bus.cfg_len < 5'd2) begin
            w_len_clamped = 5'd2;
        end else if (bus.cfg_len > LEN_MAX) begin
            w_len_clamped = LEN_MAX;
        end
    end

    assign bus.out_match = r_moore ? r_out_moore : w_hit;
    assign bus.match_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pat       <= PAT_RST;
            r_len       <= 5'd3;
            r_ovl       <= 1'b0;
            r_moore     <= 1'b0;
            r_hist      <= '0;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_out_moore <= 1'b0;
        end else if (bus.cfg_load) begin
            r_pat       <= bus.cfg_pattern;
            r_len       <= w_len_clamped;
            r_ovl       <= bus.cfg_overlap;
            r_moore     <= bus.cfg_moore;
            r_hist      <= '0;
            r_fill      <= '0;
            r_cnt       <= '0;
            r_out_moore <= 1'b0;
        end else begin
            r_out_moore <= w_hit & r_moore;
            if (bus.in_valid) begin
                r_hist <= w_window[MAX_LEN-2:0];
                // Non-overlapping: forget how many bits are valid so the next match starts fresh.
                if (w_hit && !r_ovl) begin
                    r_fill <= '0;
                end else if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + 5'd1;
                end
            end
            if (w_hit && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule
